csr_access_controller: RTL and testbench

- Sequences core CSR instructions (CSRRW/CSRRS/CSRRC and immediate forms) onto the shared CSR bus as a read-phase / optional write-phase transaction.
- Collects per-register responder strobes and returns the old value to the core.
- Flags an access as illegal when it has no responder, has several responders, or writes a read-only address.
- Sits between the core's execute stage and the bank of CSR configuration/status registers.

---
 rtl/csr_pkg.sv | 16 +
 rtl/csr_hit_checker.sv | 29 ++
 rtl/csr_access_controller.sv | 146 ++++++++++++++
 tb/tb_csr_access_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared encodings for the CSR access controller slice.
// Op codes, FSM state encoding and the read-only address field.
package csr_pkg;

    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;
    localparam logic [1:0] CSR_OP_RC = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

endpackage

// File: rtl/csr_hit_checker.sv
// csr_hit_checker: reduces the responder strobe vector to
// "nobody answered" and "more than one answered" flags.
module csr_hit_checker #(
    parameter int NUM_RESPONDERS = 8
) (
    input  logic [NUM_RESPONDERS-1:0] hit,
    output logic                      none,
    output logic                      multiple
);

    logic seen;

    // Walk the strobes; a second set bit marks a conflict.
    always_comb begin
        seen     = 1'b0;
        multiple = 1'b0;
        for (int i = 0; i < NUM_RESPONDERS; i++) begin
            if (hit[i]) begin
                if (seen) begin
                    multiple = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    assign none = ~|hit;

endmodule

// File: rtl/csr_access_controller.sv
// csr_access_controller: runs core CSR ops as read / optional write on the CSR bus.
// Define CSR_FAULT_CAPTURE_EN to add fault_address / fault_count outputs.
module csr_access_controller
    import csr_pkg::*;
#(
    parameter int NUM_RESPONDERS = 8,
    parameter int RO_CHECK       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [11:0]               req_address,
    input  logic [1:0]                req_op,
    input  logic [31:0]               req_data,
    input  logic                      req_write_suppress,
    output logic                      resp_valid,
    output logic [31:0]               resp_read_data,
    output logic                      resp_error,
`ifdef CSR_FAULT_CAPTURE_EN
    output logic [11:0]               fault_address,
    output logic [15:0]               fault_count,
`endif
    output logic                      csrReadEnable,
    output logic [11:0]               csrReadAddress,
    input  logic [31:0]               csrReadData,
    input  logic [NUM_RESPONDERS-1:0] csrRequestOutputs,
    output logic                      csrWriteEnable,
    output logic [11:0]               csrWriteAddress,
    output logic [31:0]               csrWriteData
);

    logic [1:0]  state;
    logic [11:0] addr_q;
    logic [1:0]  op_q;
    logic [31:0] data_q;
    logic        sup_q;
    logic [31:0] old_q;
    logic [31:0] new_q;
    logic        err_q;

    logic        none;
    logic        multiple;
    logic        wr_need;
    logic        bad_op;
    logic        ro_hit;
    logic        illegal;
    logic [31:0] new_val;

    csr_hit_checker #(
        .NUM_RESPONDERS(NUM_RESPONDERS)
    ) u_hit (
        .hit     (csrRequestOutputs),
        .none    (none),
        .multiple(multiple)
    );

    // Decide write need, modified value and legality from the bus sample.
    always_comb begin
        wr_need = 1'b0;
        bad_op  = 1'b0;
        new_val = data_q;
        unique case (op_q)
            CSR_OP_RW: begin
                wr_need = 1'b1;
                new_val = data_q;
            end
            CSR_OP_RS: begin
                wr_need = !sup_q;
                new_val = csrReadData | data_q;
            end
            CSR_OP_RC: begin
                wr_need = !sup_q;
                new_val = csrReadData & ~data_q;
            end
            default: bad_op = 1'b1;
        endcase
        ro_hit  = (RO_CHECK != 0) && (addr_q[11:10] == CSR_RO_FIELD)
                  && wr_need;
        illegal = none | multiple | bad_op | ro_hit;
    end

    // Transaction sequencer: latch, read, optional write, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            op_q   <= '0;
            data_q <= '0;
            sup_q  <= 1'b0;
            old_q  <= '0;
            new_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_address;
                        op_q   <= req_op;
                        data_q <= req_data;
                        sup_q  <= req_write_suppress;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    old_q <= csrReadData;
                    new_q <= new_val;
                    err_q <= illegal;
                    if (illegal || !wr_need) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef CSR_FAULT_CAPTURE_EN
    // Remember the last illegal address and count illegal responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_address <= '0;
            fault_count   <= '0;
        end else if (state == ST_DONE && err_q) begin
            fault_address <= addr_q;
            if (fault_count != 16'hFFFF) begin
                fault_count <= fault_count + 16'd1;
            end
        end
    end
`endif

    assign req_ready       = (state == ST_IDLE);
    assign csrReadEnable   = (state == ST_READ);
    assign csrReadAddress  = csrReadEnable ? addr_q : '0;
    assign csrWriteEnable  = (state == ST_WRITE);
    assign csrWriteAddress = csrWriteEnable ? addr_q : '0;
    assign csrWriteData    = csrWriteEnable ? new_q : '0;
    assign resp_valid      = (state == ST_DONE);
    assign resp_error      = resp_valid & err_q;
    assign resp_read_data  = (resp_valid && !err_q) ? old_q : '0;

endmodule

// File: tb/tb_csr_access_controller.sv
// tb_csr_access_controller: directed checks of the CSR access sequencer.
// Define CSR_FAULT_CAPTURE_EN to also check the fault capture outputs.
module tb_csr_access_controller;

    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [11:0]   req_address = '0;
    logic [1:0]    req_op = '0;
    logic [31:0]   req_data = '0;
    logic          req_write_suppress = 1'b0;
    logic          resp_valid;
    logic [31:0]   resp_read_data;
    logic          resp_error;
    logic          csrReadEnable;
    logic [11:0]   csrReadAddress;
    logic [31:0]   csrReadData = '0;
    logic [NR-1:0] csrRequestOutputs = '0;
    logic          csrWriteEnable;
    logic [11:0]   csrWriteAddress;
    logic [31:0]   csrWriteData;
`ifdef CSR_FAULT_CAPTURE_EN
    logic [11:0]   fault_address;
    logic [15:0]   fault_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    csr_access_controller #(
        .NUM_RESPONDERS(NR),
        .RO_CHECK(1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_address       (req_address),
        .req_op            (req_op),
        .req_data          (req_data),
        .req_write_suppress(req_write_suppress),
        .resp_valid        (resp_valid),
        .resp_read_data    (resp_read_data),
        .resp_error        (resp_error),
`ifdef CSR_FAULT_CAPTURE_EN
        .fault_address     (fault_address),
        .fault_count       (fault_count),
`endif
        .csrReadEnable     (csrReadEnable),
        .csrReadAddress    (csrReadAddress),
        .csrReadData       (csrReadData),
        .csrRequestOutputs (csrRequestOutputs),
        .csrWriteEnable    (csrWriteEnable),
        .csrWriteAddress   (csrWriteAddress),
        .csrWriteData      (csrWriteData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_req(
        input string         tag,
        input logic [11:0]   a,
        input logic [1:0]    op,
        input logic [31:0]   d,
        input logic          sup,
        input logic [31:0]   rd,
        input logic [NR-1:0] hits,
        input int            e_wr,
        input logic [31:0]   e_wd,
        input logic [31:0]   e_rd,
        input logic          e_err,
        input int            e_lat
    );
        int          lat;
        int          n_rd;
        int          n_wr;
        int          both;
        logic [11:0] ra;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [31:0] got_rd;
        logic        got_err;
        bit          done;
        lat = 1; n_rd = 0; n_wr = 0; both = 0;
        ra = '0; wa = '0; wd = '0; got_rd = '0; got_err = 1'b0; done = 0;
        @(negedge clk);
        req_valid          = 1'b1;
        req_address        = a;
        req_op             = op;
        req_data           = d;
        req_write_suppress = sup;
        csrReadData        = rd;
        csrRequestOutputs  = hits;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            if (csrReadEnable) begin
                n_rd++;
                ra = csrReadAddress;
            end
            if (csrWriteEnable) begin
                n_wr++;
                wa = csrWriteAddress;
                wd = csrWriteData;
            end
            if (csrReadEnable && csrWriteEnable) both++;
            if (resp_valid) begin
                done    = 1;
                got_rd  = resp_read_data;
                got_err = resp_error;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk({tag, ".resp_seen"}, 32'(done), 32'd1);
        chk({tag, ".latency"}, lat, e_lat);
        chk({tag, ".reads"}, n_rd, 32'd1);
        chk({tag, ".raddr"}, 32'(ra), 32'(a));
        chk({tag, ".writes"}, n_wr, e_wr);
        chk({tag, ".overlap"}, both, 32'd0);
        if (e_wr != 0) begin
            chk({tag, ".waddr"}, 32'(wa), 32'(a));
            chk({tag, ".wdata"}, wd, e_wd);
        end
        chk({tag, ".rdata"}, got_rd, e_rd);
        chk({tag, ".error"}, 32'(got_err), 32'(e_err));
        @(posedge clk); #1;
        chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
        chk({tag, ".valid_after"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rdy_h;
        logic [7:0] rsp_h;
        logic [7:0] ren_h;
        int         stray;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_error", 32'(resp_error), 32'd0);
        chk("rst.resp_data", resp_read_data, 32'd0);
        chk("rst.ren", 32'(csrReadEnable), 32'd0);
        chk("rst.wen", 32'(csrWriteEnable), 32'd0);
        chk("rst.raddr", 32'(csrReadAddress), 32'd0);
        chk("rst.waddr", 32'(csrWriteAddress), 32'd0);
        chk("rst.wdata", csrWriteData, 32'd0);
`ifdef CSR_FAULT_CAPTURE_EN
        chk("rst.fault_addr", 32'(fault_address), 32'd0);
        chk("rst.fault_cnt", 32'(fault_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_req("rw", 12'h300, 2'b01, 32'h1234_5678, 1'b0,
                32'h0000_00FF, 8'h01, 1, 32'h1234_5678,
                32'h0000_00FF, 1'b0, 3);
        run_req("rs_sup", 12'h305, 2'b10, 32'h0000_0000, 1'b1,
                32'hA5A5_0000, 8'h04, 0, 32'h0,
                32'hA5A5_0000, 1'b0, 2);
        run_req("rc", 12'h306, 2'b11, 32'h0000_FFFF, 1'b0,
                32'hFFFF_FFFF, 8'h02, 1, 32'hFFFF_0000,
                32'hFFFF_FFFF, 1'b0, 3);
        run_req("rs_set", 12'h301, 2'b10, 32'h0000_000F, 1'b0,
                32'h0000_00F0, 8'h80, 1, 32'h0000_00FF,
                32'h0000_00F0, 1'b0, 3);
        run_req("nohit", 12'h7C0, 2'b01, 32'h0000_0001, 1'b0,
                32'h0000_0012, 8'h00, 0, 32'h0,
                32'h0, 1'b1, 2);
`ifdef CSR_FAULT_CAPTURE_EN
        chk("nohit.fault_addr", 32'(fault_address), 32'h7C0);
        chk("nohit.fault_cnt", 32'(fault_count), 32'd1);
`endif
        run_req("ro_rw", 12'hC00, 2'b01, 32'hDEAD_BEEF, 1'b0,
                32'h0000_0055, 8'h01, 0, 32'h0,
                32'h0, 1'b1, 2);
`ifdef CSR_FAULT_CAPTURE_EN
        chk("ro_rw.fault_addr", 32'(fault_address), 32'hC00);
        chk("ro_rw.fault_cnt", 32'(fault_count), 32'd2);
`endif
        run_req("ro_rs_sup", 12'hC00, 2'b10, 32'h0, 1'b1,
                32'h0000_0055, 8'h01, 0, 32'h0,
                32'h0000_0055, 1'b0, 2);
        run_req("conflict", 12'h340, 2'b10, 32'h0000_0001, 1'b0,
                32'h0000_0003, 8'h03, 0, 32'h0,
                32'h0, 1'b1, 2);
        run_req("op00", 12'h341, 2'b00, 32'h0000_0001, 1'b0,
                32'h0000_0007, 8'h10, 0, 32'h0,
                32'h0, 1'b1, 2);

        @(negedge clk);
        req_valid          = 1'b1;
        req_address        = 12'h302;
        req_op             = 2'b01;
        req_data           = 32'h0000_0001;
        req_write_suppress = 1'b0;
        csrReadData        = 32'h0;
        csrRequestOutputs  = 8'h01;
        rdy_h = '0; rsp_h = '0; ren_h = '0;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            rdy_h = {rdy_h[6:0], req_ready};
            rsp_h = {rsp_h[6:0], resp_valid};
            ren_h = {ren_h[6:0], csrReadEnable};
            if (k == 4) req_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("b2b.ready_hist", 32'(rdy_h), 32'h11);
        chk("b2b.resp_hist", 32'(rsp_h), 32'h22);
        chk("b2b.read_hist", 32'(ren_h), 32'h88);

        @(negedge clk);
        req_valid   = 1'b1;
        req_address = 12'h310;
        req_op      = 2'b01;
        req_data    = 32'hCAFE_0001;
        csrReadData = 32'h0000_0009;
        csrRequestOutputs = 8'h01;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort.in_read", 32'(csrReadEnable), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.ready", 32'(req_ready), 32'd1);
        chk("abort.wen", 32'(csrWriteEnable), 32'd0);
        chk("abort.ren", 32'(csrReadEnable), 32'd0);
        chk("abort.resp_valid", 32'(resp_valid), 32'd0);
        chk("abort.raddr", 32'(csrReadAddress), 32'd0);
        chk("abort.wdata", csrWriteData, 32'd0);
        chk("abort.resp_data", resp_read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (csrWriteEnable || resp_valid || csrReadEnable) stray++;
        end
        chk("abort.no_activity", stray, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
